floating_point_add_sequencer: RTL and testbench

FLOATING_POINT_ADD_SEQUENCER -- requirements
Module: floating_point_add_sequencer

---
 rtl/floating_point_add_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_floating_point_add_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_add_sequencer.sv
// Multi-cycle IEEE-754 adder: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Denormals are flushed to signed zero; rounding is to nearest, ties to even.
module floating_point_add_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MENT_WIDTH = 23,
  parameter int unsigned EXPO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] floating1,
  input  logic [DATA_WIDTH-1:0] floating2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] floating_addition_out,
  output logic                  overflow,
  output logic                  invalid
);

  // Working significand: hidden bit, mantissa, then guard/round/sticky.
  localparam int unsigned SW = MENT_WIDTH + 4;
  localparam int unsigned XW = EXPO_WIDTH + 2;
  localparam logic [EXPO_WIDTH-1:0] EXP_MAX = '1;
  localparam logic [XW-1:0] EXP_TOP = {2'b00, EXP_MAX};
  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MENT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, special_val_q;
  logic                  special_q, special_inv_q, sign_q, sub_q, both_neg_q, zero_q;
  logic [XW-1:0]         exp_q;
  logic [SW-1:0]         man_a_q, man_b_q, norm_q;
  logic [SW:0]           sum_q;

  assign in_ready = (state_q == StIdle);

  // Align: unpack, order by magnitude, shift B right with sticky collection.
  logic [EXPO_WIDTH-1:0] e1, e2, ea, eb, shamt;
  logic [MENT_WIDTH-1:0] m1, m2, ma, mb;
  logic                  s1, s2, sa, swap, nan1, nan2, inf1, inf2, sp_inv, sp;
  logic [DATA_WIDTH-2:0] mag1, mag2;
  logic [MENT_WIDTH:0]   sig_a, sig_b;
  logic [SW-1:0]         ext_b, al_b;
  logic [DATA_WIDTH-1:0] sp_val;

  always_comb begin
    s1 = op1_q[DATA_WIDTH-1];
    s2 = op2_q[DATA_WIDTH-1];
    e1 = op1_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    e2 = op2_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    m1 = op1_q[MENT_WIDTH-1:0];
    m2 = op2_q[MENT_WIDTH-1:0];
    mag1 = (e1 == '0) ? '0 : {e1, m1};
    mag2 = (e2 == '0) ? '0 : {e2, m2};
    swap = mag2 > mag1;
    sa = swap ? s2 : s1;
    ea = swap ? e2 : e1;
    eb = swap ? e1 : e2;
    ma = swap ? m2 : m1;
    mb = swap ? m1 : m2;
    sig_a = (ea == '0) ? '0 : {1'b1, ma};
    sig_b = (eb == '0) ? '0 : {1'b1, mb};
    ext_b = {sig_b, 3'b000};
    shamt = ea - eb;
    al_b = (ext_b >> shamt) | SW'(|(ext_b & ~({SW{1'b1}} << shamt)));
    nan1 = (e1 == EXP_MAX) && (m1 != '0);
    nan2 = (e2 == EXP_MAX) && (m2 != '0);
    inf1 = (e1 == EXP_MAX) && (m1 == '0);
    inf2 = (e2 == EXP_MAX) && (m2 == '0);
    sp_inv = nan1 | nan2 | (inf1 & inf2 & (s1 ^ s2));
    sp = sp_inv | inf1 | inf2;
    sp_val = sp_inv ? QNAN : (inf1 ? op1_q : op2_q);
  end

  // Normalise: one-step right shift on carry, else left shift by leading zeros.
  int unsigned   lz;
  logic [SW-1:0] nrm;
  logic [XW-1:0] nexp;

  always_comb begin
    lz = SW;
    for (int unsigned i = 0; i < SW; i++) begin
      if (sum_q[i]) lz = SW - 1 - i;
    end
    if (sum_q[SW]) begin
      nrm = sum_q[SW:1];
      nexp = exp_q + XW'(1);
    end else begin
      nrm = sum_q[SW-1:0] << lz;
      nexp = exp_q - XW'(lz);
    end
    nrm[0] = nrm[0] | sum_q[0];
  end

  // Round to nearest even, renormalise on mantissa carry, then pack.
  logic [MENT_WIDTH+1:0] rnd;
  logic [MENT_WIDTH-1:0] frac;
  logic [XW-1:0]         fexp;
  logic                  up, res_ovf, res_inv;
  logic [DATA_WIDTH-1:0] res;

  always_comb begin
    up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    rnd = {1'b0, norm_q[SW-1:3]} + {{(MENT_WIDTH+1){1'b0}}, up};
    if (rnd[MENT_WIDTH+1]) begin
      fexp = exp_q + XW'(1);
      frac = rnd[MENT_WIDTH:1];
    end else begin
      fexp = exp_q;
      frac = rnd[MENT_WIDTH-1:0];
    end
    res_ovf = 1'b0;
    res_inv = 1'b0;
    if (special_q) begin
      res = special_val_q;
      res_inv = special_inv_q;
    end else if (zero_q) begin
      res = {both_neg_q, {(DATA_WIDTH-1){1'b0}}};
    end else if (!fexp[XW-1] && fexp >= EXP_TOP) begin
      res = {sign_q, EXP_MAX, {MENT_WIDTH{1'b0}}};
      res_ovf = 1'b1;
    end else if (fexp[XW-1] || fexp == '0) begin
      res = {sign_q, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {sign_q, fexp[EXPO_WIDTH-1:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_valid <= 1'b0;
      floating_addition_out <= '0;
      overflow <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op1_q <= floating1;
            op2_q <= floating2;
            state_q <= StAlign;
          end
        end
        StAlign: begin
          sign_q <= sa;
          sub_q <= s1 ^ s2;
          both_neg_q <= s1 & s2;
          exp_q <= {2'b00, ea};
          man_a_q <= {sig_a, 3'b000};
          man_b_q <= al_b;
          special_q <= sp;
          special_inv_q <= sp_inv;
          special_val_q <= sp_val;
          state_q <= StAdd;
        end
        StAdd: begin
          sum_q <= sub_q ? ({1'b0, man_a_q} - {1'b0, man_b_q})
                         : ({1'b0, man_a_q} + {1'b0, man_b_q});
          state_q <= StNorm;
        end
        StNorm: begin
          norm_q <= nrm;
          exp_q <= nexp;
          zero_q <= (sum_q == '0);
          state_q <= StRound;
        end
        StRound: begin
          floating_addition_out <= res;
          overflow <= res_ovf;
          invalid <= res_inv;
          out_valid <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            floating_addition_out <= '0;
            overflow <= 1'b0;
            invalid <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_floating_point_add_sequencer.sv
// Directed and randomized checks of the float adder sequencer against an
// exact-integer IEEE-754 single-precision reference model.
module tb_floating_point_add_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, overflow, invalid;
  logic [31:0] floating1, floating2, floating_addition_out;

  int tests = 0;
  int fails = 0;

  // Edges from the accepting edge until out_valid is visible (DONE is the
  // fifth cycle after the accepting cycle).
  localparam int LatencyEdges = 4;

  floating_point_add_sequencer #(
    .DATA_WIDTH(32),
    .MENT_WIDTH(23),
    .EXPO_WIDTH(8)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .floating1            (floating1),
    .floating2            (floating2),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .floating_addition_out(floating_addition_out),
    .overflow             (overflow),
    .invalid              (invalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact sum as a wide integer, then round to 24 bits with ties-to-even.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf, output logic inv);
    logic [31:0] x, y;
    logic [65:0] big, keep, rem, half;
    int          ex, ey, d, p, sh, er;
    logic        nan_a, nan_b, inf_a, inf_b;
    ovf = 1'b0;
    inv = 1'b0;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
      r = 32'h7FC00000;
      inv = 1'b1;
      return;
    end
    if (inf_a) begin r = a; return; end
    if (inf_b) begin r = b; return; end
    if (a[30:23] == 0 && b[30:23] == 0) begin r = {a[31] & b[31], 31'b0}; return; end
    if (a[30:23] == 0) begin r = b; return; end
    if (b[30:23] == 0) begin r = a; return; end
    if (b[30:0] > a[30:0]) begin x = b; y = a; end else begin x = a; y = b; end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    d = ex - ey;
    if (d > 40) begin r = x; return; end
    big = 66'({1'b1, x[22:0]}) << d;
    if (x[31] == y[31]) big = big + 66'({1'b1, y[22:0]});
    else big = big - 66'({1'b1, y[22:0]});
    if (big == 0) begin r = 32'h0; return; end
    p = 0;
    for (int i = 0; i < 66; i++) if (big[i]) p = i;
    if (p > 23) begin
      sh = p - 23;
      keep = big >> sh;
      rem = big & ((66'd1 << sh) - 66'd1);
      half = 66'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 66'd1;
      if (keep[24]) begin keep = keep >> 1; sh++; end
      er = ey + sh;
    end else begin
      keep = big << (23 - p);
      er = ey - (23 - p);
    end
    if (er >= 255) begin
      r = {x[31], 8'hFF, 23'b0};
      ovf = 1'b1;
    end else if (er < 1) begin
      r = {x[31], 31'b0};
    end else begin
      r = {x[31], 8'(er), keep[22:0]};
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (!in_ready && k < 20) begin step(); k++; end
    check("in_ready_before_issue", in_ready, 1);
    floating1 = a;
    floating2 = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("busy_no_ready_flags", {in_ready, out_valid, overflow, invalid}, 0);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo, input logic ei);
    int lat;
    issue(a, b);
    wait_result(lat);
    check({tag, "_latency"}, lat, LatencyEdges);
    check({tag, "_sum"}, floating_addition_out, er);
    check({tag, "_overflow"}, overflow, eo);
    check({tag, "_invalid"}, invalid, ei);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] a, b, r;
    logic        o, i;
    int          mode, e1, e2;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    floating1 = '0;
    floating2 = '0;
    step();
    step();
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", {out_valid, overflow, invalid}, 0);
    check("reset_sum", floating_addition_out, 0);
    rst = 1'b0;

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0);
    run_op("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000, 0, 0);
    run_op("neg_zeros", 32'h80000000, 32'h80000000, 32'h80000000, 0, 0);
    run_op("tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000, 0, 0);
    run_op("tie_odd", 32'h3F800001, 32'h33800000, 32'h3F800002, 0, 0);
    run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 1);
    run_op("inf_plus_one", 32'h7F800000, 32'h3F800000, 32'h7F800000, 0, 0);
    run_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 1);
    run_op("denorm_in", 32'h00000001, 32'h3F800000, 32'h3F800000, 0, 0);

    // Stall in DONE: outputs must hold while out_ready is low.
    issue(32'h7F7FFFFF, 32'h7F7FFFFF);
    wait_result(e1);
    check("stall_latency", e1, LatencyEdges);
    for (int n = 0; n < 10; n++) begin
      check("stall_hold", {out_valid, in_ready, overflow, invalid}, 4'b1010);
      check("stall_sum", floating_addition_out, 32'h7F800000);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall_release", {in_ready, out_valid, overflow}, 3'b100);

    // Reset while in NORM, with in_valid also high: the operation is dropped.
    issue(32'h3F800000, 32'h3F800000);
    step();
    step();
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("abort_idle", in_ready, 1);
    for (int n = 0; n < 8; n++) begin
      check("abort_no_valid", out_valid, 0);
      step();
    end
    run_op("after_abort", 32'h40000000, 32'h40400000, 32'h40A00000, 0, 0);

    for (int n = 0; n < 80; n++) begin
      mode = int'($urandom_range(0, 9));
      e1 = int'($urandom_range(1, 254));
      if (mode == 8) e1 = int'($urandom_range(250, 254));
      if (mode == 9) e1 = int'($urandom_range(1, 4));
      e2 = e1 + int'($urandom_range(0, 6)) - 3;
      if (mode == 5) e2 = int'($urandom_range(1, 254));
      if (e2 < 1) e2 = 1;
      if (e2 > 254) e2 = 254;
      a = {1'($urandom), 8'(e1), 23'($urandom)};
      b = {1'($urandom), 8'(e2), 23'($urandom)};
      if (mode == 6) b = {~a[31], a[30:0]};
      if (mode == 7) b = {1'($urandom), 8'h00, 23'($urandom)};
      if (mode == 4) b = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 1) ? 23'($urandom) : 23'd0};
      if ($urandom_range(0, 1) == 1) begin r = a; a = b; b = r; end
      ref_add(a, b, r, o, i);
      run_op("random", a, b, r, o, i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
